// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Round-robin arbiter that shares one external pipelined 16x16 multiplier
// among NUM_REQ requesters. One operand pair is issued per cycle at most.
// A LATENCY+1 deep tag pipeline remembers who owns each in-flight product,
// so that each product can be routed back to the requester that issued it.
module mult_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [16*NUM_REQ-1:0]  req_a,
    input  logic [16*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [15:0]            mult_a,
    output logic [15:0]            mult_b,
    output logic                   mult_issue,
    input  logic [31:0]            mult_p,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_p,
    output logic [15:0]            issue_count
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Architectural state
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]        mult_a_q, mult_a_d;
    logic [15:0]        mult_b_q, mult_b_d;
    logic               mult_issue_q, mult_issue_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_p_q, rsp_p_d;
    logic [15:0]        issue_count_q, issue_count_d;

    // Owner tags; stage LATENCY lines up with the matching product on mult_p
    logic               tag_vld_q [LATENCY+1];
    logic [IDX_W-1:0]   tag_own_q [LATENCY+1];

    // Arbitration signals
    logic [NUM_REQ-1:0] eligible;
    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic [15:0]        sel_a;
    logic [15:0]        sel_b;
    logic               xfer;
    int unsigned        cand_u;
    logic [IDX_W-1:0]   cand_idx;

    // Response decode signals
    logic               rsp_fire;
    logic [IDX_W-1:0]   rsp_own;
    logic [NUM_REQ-1:0] rsp_oh;

    // Round-robin search: first eligible index at or after rr_ptr, wrapping
    always_comb begin
        eligible  = req_valid & ~pending_q;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_u    = 0;
        cand_idx  = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand_u = 32'(rr_ptr_q) + off;
            if (cand_u >= NUM_REQ) begin
                cand_u = cand_u - NUM_REQ;
            end
            cand_idx = IDX_W'(cand_u);
            if (!grant_vld && eligible[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    // One-hot grant and operand mux for the winning requester
    always_comb begin
        grant_oh = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_vld && (grant_idx == IDX_W'(i))) begin
                grant_oh[i] = 1'b1;
                sel_a       = req_a[16*i +: 16];
                sel_b       = req_b[16*i +: 16];
            end
        end
    end

    assign req_ready = grant_oh;
    assign xfer      = |(req_valid & grant_oh);

    // Decode the tag leaving the pipeline into a one-hot response owner
    always_comb begin
        rsp_fire = tag_vld_q[LATENCY];
        rsp_own  = tag_own_q[LATENCY];
        rsp_oh   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rsp_fire && (rsp_own == IDX_W'(i))) begin
                rsp_oh[i] = 1'b1;
            end
        end
    end

    // Next-state for pending set, pointer, operand registers and response
    always_comb begin
        pending_d     = pending_q;
        rr_ptr_d      = rr_ptr_q;
        mult_issue_d  = 1'b0;
        mult_a_d      = '0;
        mult_b_d      = '0;
        issue_count_d = issue_count_q;
        rsp_valid_d   = '0;
        rsp_p_d       = rsp_p_q;

        // A returning owner is never the current winner (it is still pending),
        // so clear-then-set on the same vector cannot collide.
        if (rsp_fire) begin
            pending_d   = pending_d & ~rsp_oh;
            rsp_valid_d = rsp_oh;
            rsp_p_d     = mult_p;
        end

        if (xfer) begin
            pending_d     = pending_d | grant_oh;
            rr_ptr_d      = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
            mult_issue_d  = 1'b1;
            mult_a_d      = sel_a;
            mult_b_d      = sel_b;
            issue_count_d = issue_count_q + 16'd1;
        end
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= '0;
            rr_ptr_q      <= '0;
            mult_a_q      <= '0;
            mult_b_q      <= '0;
            mult_issue_q  <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_p_q       <= '0;
            issue_count_q <= '0;
        end else begin
            pending_q     <= pending_d;
            rr_ptr_q      <= rr_ptr_d;
            mult_a_q      <= mult_a_d;
            mult_b_q      <= mult_b_d;
            mult_issue_q  <= mult_issue_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_p_q       <= rsp_p_d;
            issue_count_q <= issue_count_d;
        end
    end

    // Tag pipeline: stage 0 mirrors mult_issue, later stages shift each edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s <= LATENCY; s++) begin
                tag_vld_q[s] <= 1'b0;
                tag_own_q[s] <= '0;
            end
        end else begin
            tag_vld_q[0] <= xfer;
            tag_own_q[0] <= grant_idx;
            for (int unsigned s = 1; s <= LATENCY; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_own_q[s] <= tag_own_q[s-1];
            end
        end
    end

    assign mult_a      = mult_a_q;
    assign mult_b      = mult_b_q;
    assign mult_issue  = mult_issue_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_p       = rsp_p_q;
    assign issue_count = issue_count_q;

endmodule
